// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_pkg
// Purpose  : Shared state encoding, default widths and saturation helper for
//            the serial neural-network layer.
// Revision : 1.0
// ============================================================================
package nn_pkg;

    localparam int DEF_NEURONS = 10;
    localparam int DEF_INPUTS  = 30;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_FRAC_W  = 12;
    localparam int SAT_W       = 128;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_BIAS  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] SAT_NONE = 2'b00;
    localparam logic [1:0] SAT_POS  = 2'b01;
    localparam logic [1:0] SAT_NEG  = 2'b10;

    // Classifies a sign-extended value against the signed range of width w.
    function automatic logic [1:0] sat_code(input logic signed [SAT_W-1:0] v,
                                            input int                      w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        if (v > hi)
            sat_code = SAT_POS;
        else if (v < lo)
            sat_code = SAT_NEG;
        else
            sat_code = SAT_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac
// Purpose  : One neuron: weight/bias storage, MAC accumulator, bias-add,
//            rescale, saturation and activation (ReLU when NN_LAYER_RELU_EN).
// Revision : 1.0
// ============================================================================
module neuron_mac
    import nn_pkg::*;
#(
    parameter int INPUTS = DEF_INPUTS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int ADDR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1,
    parameter int ACC_W  = 2 * DATA_W + $clog2(INPUTS) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_wr_w,
    input  logic                     i_wr_b,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic [ADDR_W-1:0]        i_rd_addr,
    input  logic                     i_mac_en,
    input  logic signed [DATA_W-1:0] i_x,
    input  logic                     i_bias_en,
    output logic [DATA_W-1:0]        o_result
);

    localparam int SUM_W = ACC_W + 1;

    logic [DATA_W-1:0]        r_w [INPUTS];
    logic [DATA_W-1:0]        r_bias;
    logic signed [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0]        r_result;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [SUM_W-1:0]    w_bias_ext;
    logic signed [SUM_W-1:0]    w_sum;
    logic signed [SUM_W-1:0]    w_shift;
    logic signed [SAT_W-1:0]    w_wide;
    logic [1:0]                 w_sat;
    logic [DATA_W-1:0]          w_clamped;
    logic [DATA_W-1:0]          w_act;

    assign w_prod     = $signed(r_w[i_rd_addr]) * i_x;
    assign w_bias_ext = $signed({{(SUM_W-DATA_W){r_bias[DATA_W-1]}}, r_bias}) <<< FRAC_W;
    assign w_sum      = $signed({r_acc[ACC_W-1], r_acc}) + w_bias_ext;
    assign w_shift    = w_sum >>> FRAC_W;
    assign w_wide     = $signed({{(SAT_W-SUM_W){w_shift[SUM_W-1]}}, w_shift});
    assign w_sat      = sat_code(w_wide, DATA_W);

    always_comb begin
        w_clamped = w_shift[DATA_W-1:0];
        if (w_sat == SAT_POS)
            w_clamped = {1'b0, {(DATA_W-1){1'b1}}};
        else if (w_sat == SAT_NEG)
            w_clamped = {1'b1, {(DATA_W-1){1'b0}}};
    end

`ifdef NN_LAYER_RELU_EN
    assign w_act = w_clamped[DATA_W-1] ? '0 : w_clamped;
`else
    assign w_act = w_clamped;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < INPUTS; i++)
                r_w[i] <= '0;
            r_bias <= '0;
        end else begin
            if (i_wr_w)
                r_w[i_wr_addr] <= i_wr_data;
            if (i_wr_b)
                r_bias <= i_wr_data;
        end
    end

    // The BIAS cycle both captures the result and empties the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_result <= '0;
        end else if (i_bias_en) begin
            r_acc    <= '0;
            r_result <= w_act;
        end else if (i_mac_en) begin
            r_acc <= r_acc + $signed({{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod});
        end
    end

    assign o_result = r_result;

endmodule
`default_nettype wire

// File: rtl/nn_layer_serial.sv
`default_nettype none
// ============================================================================
// Module   : nn_layer_serial
// Purpose  : Fully connected layer fed one activation per beat; results are
//            streamed out by neuron index. Define NN_LAYER_RELU_EN for ReLU.
// Revision : 1.0
// ============================================================================
module nn_layer_serial
    import nn_pkg::*;
#(
    parameter int NEURONS = DEF_NEURONS,
    parameter int INPUTS  = DEF_INPUTS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    localparam int NIDX_W = (NEURONS > 1) ? $clog2(NEURONS) : 1,
    localparam int ADDR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wr_en,
    input  logic              wr_bias,
    input  logic [NIDX_W-1:0] wr_neuron,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NIDX_W-1:0] out_idx,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(INPUTS - 1);
    localparam logic [NIDX_W-1:0] IDX_LAST = NIDX_W'(NEURONS - 1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [NIDX_W-1:0] r_idx;

    logic              w_beat;
    logic              w_fire;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_res [NEURONS];

    assign in_ready  = rst_n && (r_state == ST_LOAD);
    assign busy      = (r_state != ST_LOAD) || (r_cnt != '0);
    assign out_valid = (r_state == ST_DRAIN);
    assign out_idx   = r_idx;
    assign out_last  = out_valid && (r_idx == IDX_LAST);
    assign out_data  = w_res[r_idx];

    assign w_beat  = in_valid && in_ready;
    assign w_fire  = out_valid && out_ready;
    assign w_wr_ok = wr_en && !busy
                     && (32'(wr_neuron) < NEURONS) && (32'(wr_addr) < INPUTS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_beat) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_BIAS;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_BIAS: begin
                    r_idx   <= '0;
                    r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (w_fire) begin
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= '0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // Every neuron reads its weight at the shared input count.
    for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
        neuron_mac #(
            .INPUTS (INPUTS),
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .ADDR_W (ADDR_W)
        ) u_mac (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr_w    (w_wr_ok && !wr_bias && (wr_neuron == NIDX_W'(n))),
            .i_wr_b    (w_wr_ok &&  wr_bias && (wr_neuron == NIDX_W'(n))),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_rd_addr (r_cnt),
            .i_mac_en  (w_beat),
            .i_x       ($signed(in_data)),
            .i_bias_en (r_state == ST_BIAS),
            .o_result  (w_res[n])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_layer_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_layer_serial
// Purpose  : Directed scoreboard bench for nn_layer_serial (default params).
// Revision : 1.0
// ============================================================================
module tb_nn_layer_serial;

    localparam int N  = 10;
    localparam int I  = 30;
    localparam int FW = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        wr_en = 1'b0;
    logic        wr_bias = 1'b0;
    logic [3:0]  wr_neuron = '0;
    logic [4:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;

    nn_layer_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .wr_en     (wr_en),
        .wr_bias   (wr_bias),
        .wr_neuron (wr_neuron),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          idx;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   mw [N][I];
    int   mb [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input int n, input int x);
        longint acc;
        acc = 0;
        for (int i = 0; i < I; i++)
            acc += longint'(mw[n][i]) * longint'(x);
        acc += longint'(mb[n]) * (64'sd1 <<< FW);
        acc = acc >>> FW;
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
`ifdef NN_LAYER_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc[15:0];
    endfunction

    task automatic clear_model();
        for (int n = 0; n < N; n++) begin
            mb[n] = 0;
            for (int i = 0; i < I; i++)
                mw[n][i] = 0;
        end
    endtask

    task automatic wr(input bit b, input int n, input int a, input logic [15:0] d);
        wr_en     = 1'b1;
        wr_bias   = b;
        wr_neuron = 4'(n);
        wr_addr   = 5'(a);
        wr_data   = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (n < N && a < I) begin
            if (b) mb[n] = int'($signed(d));
            else   mw[n][a] = int'($signed(d));
        end
    endtask

    task automatic set_all_w(input logic [15:0] d);
        for (int n = 0; n < N; n++)
            for (int a = 0; a < I; a++)
                wr(1'b0, n, a, d);
    endtask

    task automatic infer(input logic [15:0] x);
        check("idle_busy", busy, 0);
        check("idle_in_ready", in_ready, 1);
        for (int i = 0; i < I; i++) begin
            in_valid = 1'b1;
            in_data  = x;
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int n = 0; n < N; n++)
            sb.push_back('{model(n, int'($signed(x))), n, (n == N - 1)});
        check("lat_t1_valid", out_valid, 0);
        check("lat_t1_in_ready", in_ready, 0);
        @(negedge clk);
        check("lat_t2_valid", out_valid, 1);
        check("lat_t2_idx", out_idx, 0);
    endtask

    task automatic drain(input int stall_at, input int stall_len, input int rst_at);
        exp_t e;
        int   guard;
        while (sb.size() > 0) begin
            guard = 0;
            while (out_valid !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (out_valid !== 1'b1) begin
                check("drain_timeout", out_valid, 1);
                sb.delete();
                break;
            end
            e = sb.pop_front();
            if (e.idx == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_out_valid", out_valid, 0);
                check("rst_out_data", out_data, 0);
                check("rst_out_idx", out_idx, 0);
                check("rst_out_last", out_last, 0);
                check("rst_in_ready", in_ready, 0);
                check("rst_busy", busy, 0);
                @(negedge clk);
                rst_n = 1'b1;
                #1;
                check("rst_rel_in_ready", in_ready, 1);
                check("rst_rel_out_valid", out_valid, 0);
                clear_model();
                sb.delete();
                break;
            end
            if (e.idx == stall_at) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_data   = 16'h7FFF;
                wr_en     = 1'b1;
                wr_bias   = 1'b1;
                wr_neuron = 4'd0;
                wr_addr   = 5'd0;
                wr_data   = 16'h7FFF;
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, e.data);
                    check("stall_idx", out_idx, e.idx);
                    check("stall_in_ready", in_ready, 0);
                end
                in_valid = 1'b0;
                wr_en    = 1'b0;
            end
            check("out_data", out_data, e.data);
            check("out_idx", out_idx, e.idx);
            check("out_last", out_last, e.last);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        clear_model();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_idx", out_idx, 0);
        check("reset_out_last", out_last, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);

        // Unity-ish weights, 30 small inputs
        set_all_w(16'h1000);
        infer(16'h0100);
        drain(-1, 0, -1);
        check("after_drain_busy", busy, 0);

        // One bias set, out-of-range writes that must not land anywhere
        wr(1'b1, 3, 0, 16'h0800);
        wr(1'b0, 10, 0, 16'h7FFF);
        wr(1'b0, 0, 30, 16'h7FFF);
        wr(1'b1, 15, 31, 16'h7FFF);
        infer(16'h0100);
        drain(4, 3, -1);
        infer(16'h0100);
        drain(-1, 0, -1);

        // Positive saturation
        wr(1'b1, 3, 0, 16'h0000);
        set_all_w(16'h7FFF);
        infer(16'h7FFF);
        drain(-1, 0, -1);

        // Negative result, interrupted by reset mid-drain
        set_all_w(16'hF000);
        infer(16'h0100);
        drain(-1, 0, 5);

        // Coefficients are back to zero after the reset
        infer(16'h0100);
        drain(-1, 0, -1);

        // Negative result again, fully drained
        set_all_w(16'hF000);
        infer(16'h0100);
        drain(-1, 0, -1);
        check("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/nn_layer_serial.md
NN_LAYER_SERIAL -- requirements
Module: nn_layer_serial

Interface
REQ-001 SHALL have parameter NEURONS, default 10, neuron count (1..64).
REQ-002 SHALL have parameter INPUTS, default 30, inputs per inference (1..1024).
REQ-003 SHALL have parameter DATA_W, default 16, signed data/weight/bias width.
REQ-004 SHALL have parameter FRAC_W, default 12, fractional bits (Q(DATA_W-FRAC_W).FRAC_W).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports in_valid/in_ready  input/output  1/1  input-stream handshake.
REQ-008 SHALL have port in_data  input  DATA_W  one input activation per beat.
REQ-009 SHALL have ports wr_en, wr_bias  input  1/1  coefficient write strobe; 1=bias, 0=weight.
REQ-010 SHALL have ports wr_neuron, wr_addr, wr_data  input  clog2(NEURONS)/clog2(INPUTS)/DATA_W  coefficient target and value.
REQ-011 SHALL have port busy  output  1  high outside idle LOAD (count 0).
REQ-012 SHALL have ports out_valid/out_ready  output/input  1/1  output-stream handshake.
REQ-013 SHALL have ports out_data, out_idx, out_last  output  DATA_W/clog2(NEURONS)/1  result, neuron index, last-neuron flag.

Function
REQ-014 FSM SHALL have states LOAD, BIAS, DRAIN; reset state LOAD, input count 0.
REQ-015 In LOAD: in_ready=1; each in_valid beat SHALL update every neuron acc += w[n][count]*in_data (full 2*DATA_W product) and increment count.
REQ-016 Beat with count==INPUTS-1 SHALL move LOAD->BIAS and clear count.
REQ-017 BIAS (one cycle) SHALL compute (acc + (bias<<FRAC_W)) >>> FRAC_W, saturate to DATA_W signed, apply activation, register all NEURONS results, clear accumulators, enter DRAIN.
REQ-018 Accumulator width SHALL be 2*DATA_W+clog2(INPUTS)+1; no intermediate overflow.
REQ-019 DRAIN SHALL emit results in index order 0..NEURONS-1, one per out_valid&&out_ready; out_last=1 at NEURONS-1; final handshake returns to LOAD.
REQ-020 Latency: last input accepted at cycle t -> out_valid with out_idx=0 at cycle t+2.
REQ-021 While out_valid && !out_ready, out_data/out_idx/out_last SHALL hold stable.
REQ-022 in_ready SHALL be 0 in BIAS and DRAIN; in_valid there ignored.
REQ-023 wr_en SHALL take effect only when busy==0; otherwise ignored, no side effect.
REQ-024 Write to wr_neuron>=NEURONS or wr_addr>=INPUTS SHALL be ignored.
REQ-025 Coefficients SHALL reset to 0 and persist across inferences.

Reset
REQ-026 rst_n low SHALL asynchronously force LOAD, count 0, accumulators 0, in_ready=0 while asserted then 1, busy=0, out_valid=0, out_data=0, out_idx=0, out_last=0, coefficients 0.
REQ-027 Reset mid-LOAD or mid-DRAIN SHALL discard the inference; no partial output after release.

Configuration
REQ-028 With NN_LAYER_RELU_EN defined, activation SHALL clamp negative saturated results to 0.
REQ-029 Without NN_LAYER_RELU_EN, activation SHALL be identity (saturated linear output).

Structure
REQ-030 Package nn_pkg SHALL hold state enum typedef, default widths, and saturation function.
REQ-031 Sub-module neuron_mac (one accumulator + bias/activation stage) SHALL be instantiated NEURONS times by generate.
REQ-032 Weights SHALL be stored in one array per neuron, combinational read at count.

Verification
REQ-033 All weights 0x1000, biases 0, 30 inputs 0x0100 -> 10 outputs 0x1E00, idx 0..9, out_last only at idx 9, first at t+2.
REQ-034 As REQ-033 with bias[3]=0x0800 -> out_idx 3 gives 0x2600, others 0x1E00.
REQ-035 Weights 0x7FFF, inputs 0x7FFF -> all outputs 0x7FFF (saturation).
REQ-036 Weights 0xF000, inputs 0x0100 -> 0x0000 with NN_LAYER_RELU_EN, 0xE200 without.
REQ-037 out_ready low 3 cycles at idx 4 -> out_data/idx held, then resumes at 4; in_ready stays 0; wr_en during drain ignored.
REQ-038 rst_n pulse at idx 5 of DRAIN -> out_valid=0 immediately; coefficients 0; next inference over all-zero coefficients gives 0x0000 outputs.
